// File: rtl/regfile_scoreboard.sv
// Dual-bank (GPR/FPR) register file with write bypass on every read port and a
// busy-bit scoreboard that stalls issue while a load result is still outstanding.
module regfile_scoreboard #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD-1:0]      rd_valid,
    input  logic [NRD-1:0]      rd_gf,
    input  logic [NRD*AW-1:0]   rd_num,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                stall,
    input  logic                wa_en,
    input  logic                wa_gf,
    input  logic [AW-1:0]       wa_num,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wm_en,
    input  logic                wm_gf,
    input  logic [AW-1:0]       wm_num,
    input  logic [XLEN-1:0]     wm_data,
    input  logic                iss_en,
    input  logic                iss_gf,
    input  logic [AW-1:0]       iss_num
);

    localparam int unsigned NSLOT = 1 << AW;

    logic [XLEN-1:0]  mem [2][NSLOT];
    logic [NSLOT-1:0] busy [2];
    logic [NSLOT-1:0] in_range;
    logic             wa_ok;
    logic             wm_ok;
    logic             iss_ok;

    // Slots beyond NREG exist only when NREG is not a power of two; they are dead.
    for (genvar k = 0; k < NSLOT; k++) begin : g_range
        assign in_range[k] = (k < NREG);
    end

    // A real storage location: in range and not the hardwired GPR r0.
    function automatic logic target_ok(input logic gf, input logic [AW-1:0] num);
        return in_range[num] && (gf || (num != '0));
    endfunction

    assign wa_ok  = wa_en  && target_ok(wa_gf, wa_num);
    assign wm_ok  = wm_en  && target_ok(wm_gf, wm_num);
    assign iss_ok = iss_en && target_ok(iss_gf, iss_num);

    // Later assignments win: wa data over wm data, iss busy-set over wm busy-clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                busy[b] <= '0;
                for (int r = 0; r < NSLOT; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else begin
            if (wm_ok) begin
                mem[wm_gf][wm_num]  <= wm_data;
                busy[wm_gf][wm_num] <= 1'b0;
            end
            if (wa_ok) begin
                mem[wa_gf][wa_num] <= wa_data;
            end
            if (iss_ok) begin
                busy[iss_gf][iss_num] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic          gf;
        logic [AW-1:0] num;
        logic          ok;
        logic          wa_hit;
        logic          wm_hit;

        assign gf     = rd_gf[i];
        assign num    = rd_num[i*AW +: AW];
        assign ok     = rstn && target_ok(gf, num);
        assign wa_hit = wa_ok && (wa_gf == gf) && (wa_num == num);
        assign wm_hit = wm_ok && (wm_gf == gf) && (wm_num == num);

        assign rd_data[i*XLEN +: XLEN] = !ok    ? '0 :
                                         wa_hit ? wa_data :
                                         wm_hit ? wm_data :
                                                  mem[gf][num];
        // A load completing this cycle already supplies its data via bypass.
        assign rd_busy[i] = ok && busy[gf][num] && !wm_hit;
    end

    assign stall = |(rd_valid & rd_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, reset sequence, and a
// randomized phase compared against an array-based model of the register file.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NRD-1:0]      rd_valid;
    logic [NRD-1:0]      rd_gf;
    logic [NRD*AW-1:0]   rd_num;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                stall;
    logic                wa_en, wa_gf, wm_en, wm_gf, iss_en, iss_gf;
    logic [AW-1:0]       wa_num, wm_num, iss_num;
    logic [XLEN-1:0]     wa_data, wm_data;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk(clk), .rstn(rstn),
        .rd_valid(rd_valid), .rd_gf(rd_gf), .rd_num(rd_num),
        .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
        .wa_en(wa_en), .wa_gf(wa_gf), .wa_num(wa_num), .wa_data(wa_data),
        .wm_en(wm_en), .wm_gf(wm_gf), .wm_num(wm_num), .wm_data(wm_data),
        .iss_en(iss_en), .iss_gf(iss_gf), .iss_num(iss_num)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays indexed [bank][register].
    logic [XLEN-1:0] m_mem  [2][NREG];
    logic            m_busy [2][NREG];

    function automatic logic is_tgt(input logic gf, input logic [AW-1:0] n);
        return gf || (n != 0);
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic gf, input logic [AW-1:0] n);
        if (!rstn || !is_tgt(gf, n)) return '0;
        if (wa_en && wa_gf == gf && wa_num == n) return wa_data;
        if (wm_en && wm_gf == gf && wm_num == n) return wm_data;
        return m_mem[gf][n];
    endfunction

    function automatic logic m_rd_busy(input logic gf, input logic [AW-1:0] n);
        if (!rstn || !is_tgt(gf, n)) return 1'b0;
        if (wm_en && wm_gf == gf && wm_num == n) return 1'b0;
        return m_busy[gf][n];
    endfunction

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NREG; r++) begin
                m_mem[b][r]  = '0;
                m_busy[b][r] = 1'b0;
            end
    endtask

    // Apply the clock-edge effect of the inputs currently driven.
    task automatic m_commit();
        if (!rstn) begin
            m_reset();
        end else begin
            if (wm_en && is_tgt(wm_gf, wm_num)) begin
                m_mem[wm_gf][wm_num]  = wm_data;
                m_busy[wm_gf][wm_num] = 1'b0;
            end
            if (wa_en && is_tgt(wa_gf, wa_num)) m_mem[wa_gf][wa_num] = wa_data;
            if (iss_en && is_tgt(iss_gf, iss_num)) m_busy[iss_gf][iss_num] = 1'b1;
        end
    endtask

    typedef struct {
        logic wa_en; logic wa_gf; logic [AW-1:0] wa_num; logic [XLEN-1:0] wa_data;
        logic wm_en; logic wm_gf; logic [AW-1:0] wm_num; logic [XLEN-1:0] wm_data;
        logic iss_en; logic iss_gf; logic [AW-1:0] iss_num;
        logic [1:0] rv; logic [1:0] rg; logic [AW-1:0] n0; logic [AW-1:0] n1;
        logic [XLEN-1:0] e0; logic [XLEN-1:0] e1; logic [1:0] ebusy; logic estall;
    } vec_t;

    vec_t tbl [15];

    task automatic apply(input vec_t v);
        wa_en = v.wa_en;   wa_gf = v.wa_gf;   wa_num = v.wa_num;   wa_data = v.wa_data;
        wm_en = v.wm_en;   wm_gf = v.wm_gf;   wm_num = v.wm_num;   wm_data = v.wm_data;
        iss_en = v.iss_en; iss_gf = v.iss_gf; iss_num = v.iss_num;
        rd_valid = v.rv;   rd_gf = v.rg;      rd_num = {v.n1, v.n0};
    endtask

    task automatic idle();
        wa_en = 0; wa_gf = 0; wa_num = '0; wa_data = '0;
        wm_en = 0; wm_gf = 0; wm_num = '0; wm_data = '0;
        iss_en = 0; iss_gf = 0; iss_num = '0;
        rd_valid = '0; rd_gf = '0; rd_num = '0;
    endtask

    task automatic expect_ports(input string tag, input logic [XLEN-1:0] e0,
                                input logic [XLEN-1:0] e1, input logic [1:0] eb,
                                input logic es);
        check({tag, "_d0"}, 64'(rd_data[XLEN-1:0]), 64'(e0));
        check({tag, "_d1"}, 64'(rd_data[2*XLEN-1:XLEN]), 64'(e1));
        check({tag, "_busy"}, 64'(rd_busy), 64'(eb));
        check({tag, "_stall"}, 64'(stall), 64'(es));
    endtask

    initial begin
        //          wa                      wm                      iss        rv     rg     n0  n1  e0            e1            eb     es
        tbl[0]  = '{1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0,             0, 0, 0,   2'b00, 2'b01, 0,  0,  32'hDEADBEEF, 32'h0,  2'b00, 0};
        tbl[1]  = '{1, 0, 0, 32'h5,        0, 0, 0, 0,             0, 0, 0,   2'b11, 2'b01, 0,  0,  32'hDEADBEEF, 32'h0,  2'b00, 0};
        tbl[2]  = '{1, 0, 3, 32'h12,       0, 0, 0, 0,             0, 0, 0,   2'b11, 2'b00, 3,  0,  32'h12,       32'h0,  2'b00, 0};
        tbl[3]  = '{0, 0, 0, 0,            0, 0, 0, 0,             1, 0, 5,   2'b10, 2'b00, 3,  5,  32'h12,       32'h0,  2'b00, 0};
        tbl[4]  = '{0, 0, 0, 0,            0, 0, 0, 0,             0, 0, 0,   2'b01, 2'b00, 5,  3,  32'h0,        32'h12, 2'b01, 1};
        tbl[5]  = '{0, 0, 0, 0,            0, 0, 0, 0,             1, 0, 7,   2'b01, 2'b00, 5,  7,  32'h0,        32'h0,  2'b01, 1};
        tbl[6]  = '{0, 0, 0, 0,            1, 0, 5, 32'h77,        0, 0, 0,   2'b01, 2'b00, 5,  7,  32'h77,       32'h0,  2'b10, 0};
        tbl[7]  = '{1, 0, 7, 32'h1,        1, 0, 7, 32'h2,         0, 0, 0,   2'b11, 2'b00, 7,  5,  32'h1,        32'h77, 2'b00, 0};
        tbl[8]  = '{0, 0, 0, 0,            0, 0, 0, 0,             1, 1, 9,   2'b11, 2'b10, 7,  9,  32'h1,        32'h0,  2'b00, 0};
        tbl[9]  = '{0, 0, 0, 0,            1, 1, 9, 32'h99,        1, 1, 9,   2'b11, 2'b11, 9,  9,  32'h99,       32'h99, 2'b00, 0};
        tbl[10] = '{0, 0, 0, 0,            0, 0, 0, 0,             0, 0, 0,   2'b01, 2'b11, 9,  9,  32'h99,       32'h99, 2'b11, 1};
        tbl[11] = '{1, 0, 4, 32'hAB,       0, 0, 0, 0,             1, 0, 2,   2'b11, 2'b00, 2,  4,  32'h0,        32'hAB, 2'b00, 0};
        tbl[12] = '{0, 0, 0, 0,            0, 0, 0, 0,             1, 0, 4,   2'b01, 2'b00, 2,  4,  32'h0,        32'hAB, 2'b01, 1};
        tbl[13] = '{0, 0, 0, 0,            0, 0, 0, 0,             1, 0, 0,   2'b11, 2'b00, 0,  4,  32'h0,        32'hAB, 2'b10, 1};
        tbl[14] = '{0, 0, 0, 0,            0, 0, 0, 0,             0, 0, 0,   2'b01, 2'b00, 0,  2,  32'h0,        32'h0,  2'b10, 0};

        idle();
        rstn = 1'b0;
        rd_valid = 2'b11; rd_gf = 2'b10; rd_num = {5'd3, 5'd1};
        m_reset();
        @(negedge clk);
        #1 expect_ports("in_reset", '0, '0, 2'b00, 1'b0);
        @(posedge clk);

        // Directed vector table; the model tracks along so later phases stay in sync.
        for (int v = 0; v < 15; v++) begin
            @(negedge clk);
            rstn = 1'b1;
            apply(tbl[v]);
            #1 expect_ports($sformatf("vec%0d", v), tbl[v].e0, tbl[v].e1, tbl[v].ebusy, tbl[v].estall);
            m_commit();
        end

        // One reset cycle with r2/r4 busy and a write that must be ignored.
        @(negedge clk);
        idle();
        rstn = 1'b0;
        wa_en = 1; wa_num = 5'd6; wa_data = 32'hCAFE;
        rd_valid = 2'b11; rd_num = {5'd4, 5'd2};
        #1 expect_ports("rst_hold", '0, '0, 2'b00, 1'b0);
        m_commit();
        @(negedge clk);
        idle();
        rstn = 1'b1;
        rd_valid = 2'b11; rd_num = {5'd4, 5'd2};
        #1 expect_ports("rst_after", '0, '0, 2'b00, 1'b0);
        m_commit();
        @(negedge clk);
        idle();
        wm_en = 1; wm_num = 5'd2; wm_data = 32'h55;
        rd_valid = 2'b11; rd_gf = 2'b10; rd_num = {5'd0, 5'd6};
        #1 expect_ports("late_wm", '0, '0, 2'b00, 1'b0);
        m_commit();
        @(negedge clk);
        idle();
        rd_valid = 2'b11; rd_num = {5'd2, 5'd2};
        #1 expect_ports("late_wm_rd", 32'h55, 32'h55, 2'b00, 1'b0);
        m_commit();

        // Randomized traffic over a small register window to force collisions.
        for (int c = 0; c < 600; c++) begin
            logic [XLEN-1:0] e0, e1;
            logic [1:0]      eb;
            @(negedge clk);
            rstn     = ($urandom_range(0, 79) != 0);
            wa_en    = 1'($urandom);  wa_gf = 1'($urandom);  wa_num = 5'($urandom_range(0, 7));  wa_data = $urandom;
            wm_en    = 1'($urandom);  wm_gf = 1'($urandom);  wm_num = 5'($urandom_range(0, 7));  wm_data = $urandom;
            iss_en   = 1'($urandom);  iss_gf = 1'($urandom); iss_num = 5'($urandom_range(0, 7));
            rd_valid = 2'($urandom);  rd_gf = 2'($urandom);
            rd_num   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            e0 = m_read(rd_gf[0], rd_num[AW-1:0]);
            e1 = m_read(rd_gf[1], rd_num[2*AW-1:AW]);
            eb = {m_rd_busy(rd_gf[1], rd_num[2*AW-1:AW]), m_rd_busy(rd_gf[0], rd_num[AW-1:0])};
            #1 expect_ports($sformatf("rand%0d", c), e0, e1, eb, |(rd_valid & eb));
            m_commit();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
